poly1305_mac_engine: RTL and testbench

Parametrised, fully sequential Poly1305 one-time authenticator for the AEAD datapath. It accepts a 256-bit one-time key (r‖s) from the ChaCha20 block-0 output and a stream of up to 16-byte message blocks with byte counts. It produces the 128-bit tag and, in verify mode, a tag-match flag. It replaces the fixed-width accumulate/multiply/reduce handshake with one engine that has:

- a configurable multiplier digit width,
- partial-block padding,
- empty-message support,
- abort,
- a single per-message tag strobe.

---
 rtl/poly1305_mac_engine.sv | 187 ++++++++++++++++++
 tb/tb_poly1305_mac_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly1305_mac_engine.sv
// Poly1305 one-time authenticator: sequential digit-serial multiply by r, two-pass
// mod 2^130-5 reduction, s-add tag and optional tag compare in one FSM.
module poly1305_mac_engine #(
  parameter int unsigned LIMB_W    = 32,
  parameter bit          VERIFY_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         abort_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [255:0] key_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [127:0] blk_data_i,
  input  logic [4:0]   blk_bytes_i,
  input  logic         blk_last_i,
  input  logic         verify_i,
  input  logic [127:0] exp_tag_i,
  output logic         tag_valid_o,
  output logic [127:0] tag_o,
  output logic         tag_ok_o,
  output logic         busy_o
);

  localparam int unsigned NLIMB = 128 / LIMB_W;
  localparam int unsigned KW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam int unsigned PPW   = 131 + LIMB_W;
  localparam logic [127:0] R_CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
  localparam logic [130:0] P_MOD   = 131'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;

  typedef enum logic [2:0] {
    S_IDLE, S_KEYED, S_MUL, S_RED1, S_RED2, S_FINAL
  } state_t;

  state_t          state_q;
  logic [127:0]    r_q;
  logic [127:0]    s_q;
  logic [129:0]    acc_q;
  logic [130:0]    a_q;
  logic            last_q;
  logic [258:0]    prod_q;
  logic [KW-1:0]   k_q;
  logic            verify_q;
  logic [127:0]    exp_q;
  logic [127:0]    tag_q;
  logic            tag_valid_q;
  logic            tag_ok_q;

  logic [4:0]      nb;
  logic [128:0]    blk_n;
  logic [130:0]    a_d;
  logic [8:0]      shamt;
  logic [LIMB_W-1:0] r_limb;
  logic [PPW-1:0]  pp;
  logic [258:0]    prod_mul_d;
  logic [128:0]    prod_hi;
  logic [258:0]    prod_red_d;
  logic [130:0]    red_t;
  logic [129:0]    acc_d;
  logic [127:0]    tag_fin_d;
  logic [127:0]    tag_empty_d;
  logic            ok_fin_d;
  logic            ok_empty_d;

  // Block padding, one digit-product step, folding of bits above 2^130 and final tag math.
  always_comb begin
    nb = (blk_bytes_i > 5'd16) ? 5'd16 : blk_bytes_i;
    blk_n = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < nb) blk_n[8*i +: 8] = blk_data_i[8*i +: 8];
    end
    blk_n = blk_n | (129'(1) << {nb, 3'b000});
    a_d   = 131'(acc_q) + 131'(blk_n);

    shamt      = 9'(k_q) * 9'(LIMB_W);
    r_limb     = LIMB_W'(r_q >> shamt);
    pp         = PPW'(a_q) * PPW'(r_limb);
    prod_mul_d = prod_q + (259'(pp) << shamt);

    // 2^130 == 5 (mod p), so the high part folds back in multiplied by 5.
    prod_hi    = prod_q[258:130];
    prod_red_d = 259'(prod_q[129:0]) + 259'({prod_hi, 2'b00}) + 259'(prod_hi);
    red_t      = prod_red_d[130:0];
    acc_d      = (red_t >= P_MOD) ? 130'(red_t - P_MOD) : red_t[129:0];

    tag_fin_d   = acc_d[127:0] + s_q;
    tag_empty_d = acc_q[127:0] + s_q;
    ok_fin_d    = VERIFY_EN && verify_q && (tag_fin_d == exp_q);
    ok_empty_d  = VERIFY_EN && verify_q && (tag_empty_d == exp_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      s_q         <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      last_q      <= 1'b0;
      prod_q      <= '0;
      k_q         <= '0;
      verify_q    <= 1'b0;
      exp_q       <= '0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_ok_q    <= 1'b0;
    end else if (abort_i) begin
      // Abort drops the key material but leaves the last tag readable.
      state_q     <= S_IDLE;
      r_q         <= '0;
      s_q         <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      last_q      <= 1'b0;
      prod_q      <= '0;
      k_q         <= '0;
      verify_q    <= 1'b0;
      exp_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_ok_q    <= 1'b0;
    end else begin
      tag_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_valid_i) begin
            r_q      <= key_i[127:0] & R_CLAMP;
            s_q      <= key_i[255:128];
            acc_q    <= '0;
            verify_q <= verify_i;
            exp_q    <= exp_tag_i;
            tag_q    <= '0;
            tag_ok_q <= 1'b0;
            state_q  <= S_KEYED;
          end
        end
        S_KEYED: begin
          if (blk_valid_i) begin
            if (blk_last_i && (blk_bytes_i == 5'd0)) begin
              tag_q       <= tag_empty_d;
              tag_ok_q    <= ok_empty_d;
              tag_valid_q <= 1'b1;
              state_q     <= S_FINAL;
            end else begin
              a_q     <= a_d;
              last_q  <= blk_last_i;
              prod_q  <= '0;
              k_q     <= '0;
              state_q <= S_MUL;
            end
          end
        end
        S_MUL: begin
          prod_q <= prod_mul_d;
          if (k_q == KW'(NLIMB - 1)) state_q <= S_RED1;
          else                       k_q     <= k_q + 1'b1;
        end
        S_RED1: begin
          prod_q  <= prod_red_d;
          state_q <= S_RED2;
        end
        S_RED2: begin
          acc_q  <= acc_d;
          prod_q <= '0;
          if (last_q) begin
            tag_q       <= tag_fin_d;
            tag_ok_q    <= ok_fin_d;
            tag_valid_q <= 1'b1;
            state_q     <= S_FINAL;
          end else begin
            state_q <= S_KEYED;
          end
        end
        S_FINAL: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign key_ready_o = (state_q == S_IDLE);
  assign blk_ready_o = (state_q == S_KEYED);
  assign busy_o      = (state_q != S_IDLE);
  assign tag_valid_o = tag_valid_q;
  assign tag_o       = tag_q;
  assign tag_ok_o    = tag_ok_q;

endmodule

// File: tb/tb_poly1305_mac_engine.sv
// Bench for poly1305_mac_engine: three digit widths, RFC 8439 vectors, a wide-integer
// reference model for random messages, and a tag scoreboard fed at block hand-off.
module tb_poly1305_mac_engine;

  localparam logic [127:0] R_CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
  localparam logic [259:0] P260    = (260'(1) << 130) - 260'(5);

  typedef struct {
    int           idx;
    logic [127:0] tag;
    logic         ok;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, abort;
  logic         key_valid [3];
  logic         blk_valid [3];
  logic [255:0] key;
  logic [127:0] blk_data, exp_tag;
  logic [4:0]   blk_bytes;
  logic         blk_last, verify;
  logic         key_ready [3];
  logic         blk_ready [3];
  logic         tag_valid [3];
  logic         tag_ok    [3];
  logic         busy      [3];
  logic [127:0] tag       [3];

  exp_t         sb[$];
  byte unsigned msg[$];
  int           blen_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LW = (g == 0) ? 8 : ((g == 1) ? 32 : 128);
    poly1305_mac_engine #(.LIMB_W(LW), .VERIFY_EN(1'b1)) u_dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .abort_i     (abort),
      .key_valid_i (key_valid[g]),
      .key_ready_o (key_ready[g]),
      .key_i       (key),
      .blk_valid_i (blk_valid[g]),
      .blk_ready_o (blk_ready[g]),
      .blk_data_i  (blk_data),
      .blk_bytes_i (blk_bytes),
      .blk_last_i  (blk_last),
      .verify_i    (verify),
      .exp_tag_i   (exp_tag),
      .tag_valid_o (tag_valid[g]),
      .tag_o       (tag[g]),
      .tag_ok_o    (tag_ok[g]),
      .busy_o      (busy[g])
    );
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int nlimb(input int idx);
    return (idx == 0) ? 16 : ((idx == 1) ? 4 : 1);
  endfunction

  function automatic logic [255:0] bswap(input logic [255:0] x, input int nbytes);
    logic [255:0] y;
    y = '0;
    for (int i = 0; i < nbytes; i++) y[8*i +: 8] = x[8*(nbytes-1-i) +: 8];
    return y;
  endfunction

  // Reference: acc' = ((acc + padded block) * r) mod (2^130 - 5) with plain wide arithmetic.
  function automatic logic [129:0] poly_step(input logic [129:0] acc, input logic [127:0] d,
                                             input int nb, input logic [127:0] r);
    logic [259:0] n, prod;
    n = '0;
    for (int i = 0; i < nb; i++) n[8*i +: 8] = d[8*i +: 8];
    n[8*nb] = 1'b1;
    prod = (260'(acc) + n) * 260'(r);
    return 130'(prod % P260);
  endfunction

  // Scoreboard consumer plus strobe-width and tag-hold checks.
  logic         prev_tv  [3];
  logic         prev_ok  [3];
  logic [127:0] prev_tag [3];
  initial for (int i = 0; i < 3; i++) prev_tv[i] = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (prev_tv[i]) begin
        check("tag_valid_width", 128'(tag_valid[i]), 128'(0));
        check("tag_hold", tag[i], prev_tag[i]);
        check("tag_ok_hold", 128'(tag_ok[i]), 128'(prev_ok[i]));
      end
      if (tag_valid[i] === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_tag_valid", 128'(i + 1), 128'(0));
        end else begin
          e = sb.pop_front();
          check("tag_instance", 128'(i), 128'(e.idx));
          check("tag_value", tag[i], e.tag);
          check("tag_ok", 128'(tag_ok[i]), 128'(e.ok));
          check("tag_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
      prev_tv[i]  = (tag_valid[i] === 1'b1);
      prev_tag[i] = tag[i];
      prev_ok[i]  = tag_ok[i];
    end
  end

  task automatic send_key(input int idx, input logic [255:0] k, input logic v,
                          input logic [127:0] et, output int t);
    int n;
    n = 0;
    key = k; verify = v; exp_tag = et; key_valid[idx] = 1'b1;
    @(negedge clk);
    while (key_ready[idx] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("key_ready_wait", 128'(key_ready[idx]), 128'(1));
    t = cyc;
    @(posedge clk); #1;
    key_valid[idx] = 1'b0;
  endtask

  task automatic send_block(input int idx, input logic [127:0] d, input logic [4:0] bb,
                            input logic last, output int b);
    int n;
    n = 0;
    blk_data = d; blk_bytes = bb; blk_last = last; blk_valid[idx] = 1'b1;
    @(negedge clk);
    while (blk_ready[idx] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("blk_ready_wait", 128'(blk_ready[idx]), 128'(1));
    b = cyc;
    @(posedge clk); #1;
    blk_valid[idx] = 1'b0;
  endtask

  // Sends msg split as blen_q; expected tag comes from the model unless a known vector is given.
  task automatic run_msg(input int idx, input logic [255:0] k, input logic v,
                         input logic [127:0] et, input bit use_known,
                         input logic [127:0] known, input bit poke);
    logic [127:0] r, s, d, tg;
    logic [129:0] acc;
    logic [4:0]   bb;
    int t, b, bprev, off, nb;
    exp_t e;
    r = k[127:0] & R_CLAMP; s = k[255:128]; acc = '0; off = 0; b = 0;
    send_key(idx, k, v, et, t);
    if (blen_q.size() == 0) begin
      send_block(idx, {$urandom(), $urandom(), $urandom(), $urandom()}, 5'd0, 1'b1, b);
      check("blk_ready_latency", 128'(b), 128'(t + 1));
      e.cyc = b + 1;
    end else begin
      for (int j = 0; j < blen_q.size(); j++) begin
        nb = blen_q[j];
        d  = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < nb; i++) d[8*i +: 8] = msg[off + i];
        off += nb;
        acc = poly_step(acc, d, nb, r);
        bb  = (nb == 16 && $urandom_range(0, 1) == 1) ? 5'($urandom_range(17, 31)) : 5'(nb);
        bprev = b;
        send_block(idx, d, bb, j == blen_q.size() - 1, b);
        if (j == 0) check("blk_ready_latency", 128'(b), 128'(t + 1));
        else        check("blk_throughput", 128'(b), 128'(bprev + nlimb(idx) + 3));
        if (poke && j == 0) begin
          key = ~k; key_valid[idx] = 1'b1;
          @(negedge clk);
          check("key_ack_in_mul", 128'(key_ready[idx]), 128'(0));
          check("busy_in_mul", 128'(busy[idx]), 128'(1));
          @(posedge clk); #1;
          key_valid[idx] = 1'b0;
        end
      end
      e.cyc = b + nlimb(idx) + 3;
    end
    tg = use_known ? known : (acc[127:0] + s);
    e.idx = idx; e.tag = tg; e.ok = v && (tg == et);
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("tag_drain", 128'(sb.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  task automatic load_str(input string str);
    msg.delete();
    for (int i = 0; i < str.len(); i++) msg.push_back(str[i]);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rfc_key, k;
    logic [127:0] rfc_tag, s_val;
    int t, b, nblk, l;

    reset = 1'b1; abort = 1'b0; key = '0; blk_data = '0; blk_bytes = '0;
    blk_last = 1'b0; verify = 1'b0; exp_tag = '0;
    for (int i = 0; i < 3; i++) begin key_valid[i] = 1'b0; blk_valid[i] = 1'b0; end
    rfc_key = bswap(256'h85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b, 32);
    rfc_tag = 128'(bswap(256'ha8061dc1305136c6c22b8baf0c0127a9, 16));

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_key_ready", 128'(key_ready[i]), 128'(1));
      check("rst_blk_ready", 128'(blk_ready[i]), 128'(0));
      check("rst_busy", 128'(busy[i]), 128'(0));
      check("rst_tag_valid", 128'(tag_valid[i]), 128'(0));
      check("rst_tag", tag[i], 128'(0));
      check("rst_tag_ok", 128'(tag_ok[i]), 128'(0));
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // RFC 8439 2.5.2 at LIMB_W = 8, 32, 128
    for (int i = 0; i < 3; i++) begin
      load_str("Cryptographic Forum Research Group");
      blen_q = '{16, 16, 2};
      run_msg(i, rfc_key, 1'b0, '0, 1'b1, rfc_tag, 1'b0);
      wait_drain();
    end

    // A.3 #5: reduction edge
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back(8'hff);
    blen_q = '{16};
    run_msg(1, {128'h0, 128'h2}, 1'b0, '0, 1'b1, 128'h3, 1'b0);
    wait_drain();

    // A.3 #6: s-add wraps modulo 2^128
    msg.delete();
    msg.push_back(8'h02);
    for (int i = 1; i < 16; i++) msg.push_back(8'h00);
    blen_q = '{16};
    run_msg(1, {{128{1'b1}}, 128'h2}, 1'b0, '0, 1'b1, 128'h3, 1'b0);
    wait_drain();

    // Empty message: tag is s, strobe two cycles after the key
    s_val = 128'h0123456789abcdef0123456789abcdef;
    msg.delete(); blen_q.delete();
    run_msg(1, {s_val, 128'h5555aaaa5555aaaa5555aaaa5555aaaa}, 1'b0, '0, 1'b1, s_val, 1'b0);
    wait_drain();
    run_msg(2, {s_val, 128'h1}, 1'b1, s_val, 1'b1, s_val, 1'b0);
    wait_drain();

    // Verify mode: matching and bit-0-flipped expected tag
    for (int i = 0; i < 2; i++) begin
      load_str("Cryptographic Forum Research Group");
      blen_q = '{16, 16, 2};
      run_msg(i, rfc_key, 1'b1, rfc_tag, 1'b1, rfc_tag, 1'b0);
      wait_drain();
      load_str("Cryptographic Forum Research Group");
      run_msg(i, rfc_key, 1'b1, rfc_tag ^ 128'h1, 1'b1, rfc_tag, 1'b0);
      wait_drain();
    end

    // Abort in the second MUL cycle
    load_str("Cryptographic Forum Research Group");
    send_key(1, rfc_key, 1'b0, '0, t);
    send_block(1, {msg[15], msg[14], msg[13], msg[12], msg[11], msg[10], msg[9], msg[8],
                   msg[7], msg[6], msg[5], msg[4], msg[3], msg[2], msg[1], msg[0]},
               5'd16, 1'b0, b);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 128'(busy[1]), 128'(0));
    check("abort_key_ready", 128'(key_ready[1]), 128'(1));
    check("abort_blk_ready", 128'(blk_ready[1]), 128'(0));
    repeat (10) @(posedge clk);
    #1;
    blen_q = '{16, 16, 2};
    run_msg(1, rfc_key, 1'b0, '0, 1'b1, rfc_tag, 1'b0);
    wait_drain();

    // key_valid during MUL must not be taken
    load_str("Cryptographic Forum Research Group");
    run_msg(1, rfc_key, 1'b0, '0, 1'b1, rfc_tag, 1'b1);
    wait_drain();

    // blk_valid while IDLE is ignored
    blk_data = '0; blk_bytes = 5'd0; blk_last = 1'b1; blk_valid[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_blk_ready", 128'(blk_ready[1]), 128'(0));
      check("idle_busy", 128'(busy[1]), 128'(0));
    end
    @(posedge clk); #1;
    blk_valid[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Random messages, partial non-last blocks and junk beyond blk_bytes, against the model
    for (int m = 0; m < 8; m++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      nblk = $urandom_range(1, 4);
      msg.delete(); blen_q.delete();
      for (int j = 0; j < nblk; j++) begin
        l = (m < 2) ? 16 : $urandom_range(1, 16);
        blen_q.push_back(l);
        for (int i = 0; i < l; i++) msg.push_back(8'($urandom_range(0, 255)));
      end
      run_msg(m % 3, k, 1'b0, '0, 1'b0, '0, 1'b0);
      wait_drain();
    end

    // Reset clears the held tag
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_tag", tag[1], 128'(0));
    check("reset_tag_ok", 128'(tag_ok[1]), 128'(0));
    check("reset_key_ready", 128'(key_ready[1]), 128'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
